// File: rtl/rv_decode_pkg.sv
`default_nettype none
// ============================================================================
// Module : rv_decode_pkg
// Brief  : Opcode, ALU-control and write-back encodings shared by the decoder.
// Rev    : 1.0  initial release
// ============================================================================
package rv_decode_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_MUL    = 5'd2;
    localparam logic [4:0] ALU_AND    = 5'd10;
    localparam logic [4:0] ALU_OR     = 5'd11;
    localparam logic [4:0] ALU_XOR    = 5'd12;
    localparam logic [4:0] ALU_SLL    = 5'd14;
    localparam logic [4:0] ALU_SRL    = 5'd15;
    localparam logic [4:0] ALU_SRA    = 5'd16;
    localparam logic [4:0] ALU_SLTU   = 5'd17;
    localparam logic [4:0] ALU_SLT    = 5'd18;

    localparam logic [1:0] WB_PC4     = 2'd0;
    localparam logic [1:0] WB_ALU     = 2'd1;
    localparam logic [1:0] WB_IMM     = 2'd2;
    localparam logic [1:0] WB_MEM     = 2'd3;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [4:0] alu_ctl;
        logic       alu_src1;
        logic       alu_src2;
        logic [1:0] wb_sel;
        logic       reg_wr;
        logic       mem_rd;
        logic       mem_wr;
        logic [2:0] rw_type;
        logic       branch;
        logic [2:0] br_type;
        logic       jump;
        logic       illegal;
    } dec_ctl_t;

    // Base integer ALU op shared by OP and OP-IMM (funct7 selects SUB/SRA elsewhere).
    function automatic logic [4:0] base_alu(input logic [2:0] funct3);
        case (funct3)
            3'd0:    base_alu = ALU_ADD;
            3'd1:    base_alu = ALU_SLL;
            3'd2:    base_alu = ALU_SLT;
            3'd3:    base_alu = ALU_SLTU;
            3'd4:    base_alu = ALU_XOR;
            3'd5:    base_alu = ALU_SRL;
            3'd6:    base_alu = ALU_OR;
            default: base_alu = ALU_AND;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv_inst_decode.sv
`default_nettype none
// ============================================================================
// Module : rv_inst_decode
// Brief  : Combinational RV32I/M field, immediate and legality decode.
// Rev    : 1.0  initial release
// ============================================================================
module rv_inst_decode
    import rv_decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int M_EXT = 1
) (
    input  logic [31:0]     i_inst,
    output dec_ctl_t        o_ctl,
    output logic [XLEN-1:0] o_imm,
    output logic            o_uses_rs1,
    output logic            o_uses_rs2
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [31:0] w_imm32;
    logic        w_uses_rs1;
    logic        w_uses_rs2;
    dec_ctl_t    w_ctl;

    assign w_opcode = i_inst[6:0];
    assign w_funct3 = i_inst[14:12];
    assign w_funct7 = i_inst[31:25];

    always_comb begin
        w_ctl         = '0;
        w_ctl.rs1     = i_inst[19:15];
        w_ctl.rs2     = i_inst[24:20];
        w_ctl.rd      = i_inst[11:7];
        w_ctl.alu_ctl = ALU_ADD;
        w_ctl.wb_sel  = WB_ALU;
        w_imm32       = '0;
        w_uses_rs1    = 1'b0;
        w_uses_rs2    = 1'b0;
        case (w_opcode)
            OPC_LUI: begin
                w_imm32        = {i_inst[31:12], 12'b0};
                w_ctl.alu_src2 = 1'b1;
                w_ctl.wb_sel   = WB_IMM;
                w_ctl.reg_wr   = 1'b1;
            end
            OPC_AUIPC: begin
                w_imm32        = {i_inst[31:12], 12'b0};
                w_ctl.alu_src1 = 1'b1;
                w_ctl.alu_src2 = 1'b1;
                w_ctl.reg_wr   = 1'b1;
            end
            OPC_JAL: begin
                w_imm32        = {{12{i_inst[31]}}, i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
                w_ctl.alu_src1 = 1'b1;
                w_ctl.alu_src2 = 1'b1;
                w_ctl.wb_sel   = WB_PC4;
                w_ctl.reg_wr   = 1'b1;
                w_ctl.jump     = 1'b1;
            end
            OPC_JALR: begin
                w_imm32        = {{20{i_inst[31]}}, i_inst[31:20]};
                w_ctl.alu_src2 = 1'b1;
                w_ctl.wb_sel   = WB_PC4;
                w_ctl.reg_wr   = 1'b1;
                w_ctl.jump     = 1'b1;
                w_ctl.illegal  = (w_funct3 != 3'd0);
                w_uses_rs1     = 1'b1;
            end
            OPC_BRANCH: begin
                w_imm32        = {{20{i_inst[31]}}, i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
                w_ctl.branch   = 1'b1;
                w_ctl.br_type  = w_funct3;
                w_ctl.illegal  = (w_funct3 == 3'd2) || (w_funct3 == 3'd3);
                w_uses_rs1     = 1'b1;
                w_uses_rs2     = 1'b1;
            end
            OPC_LOAD: begin
                w_imm32        = {{20{i_inst[31]}}, i_inst[31:20]};
                w_ctl.alu_src2 = 1'b1;
                w_ctl.wb_sel   = WB_MEM;
                w_ctl.reg_wr   = 1'b1;
                w_ctl.mem_rd   = 1'b1;
                w_ctl.rw_type  = w_funct3;
                w_ctl.illegal  = (w_funct3 == 3'd3) || (w_funct3 > 3'd5);
                w_uses_rs1     = 1'b1;
            end
            OPC_STORE: begin
                w_imm32        = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
                w_ctl.alu_src2 = 1'b1;
                w_ctl.mem_wr   = 1'b1;
                w_ctl.rw_type  = w_funct3;
                w_ctl.illegal  = (w_funct3 > 3'd2);
                w_uses_rs1     = 1'b1;
                w_uses_rs2     = 1'b1;
            end
            OPC_OP_IMM: begin
                w_imm32        = {{20{i_inst[31]}}, i_inst[31:20]};
                w_ctl.alu_src2 = 1'b1;
                w_ctl.reg_wr   = 1'b1;
                w_ctl.alu_ctl  = base_alu(w_funct3);
                w_uses_rs1     = 1'b1;
                // Shift-immediates carry funct7 in the upper immediate bits.
                if (w_funct3 == 3'd1) begin
                    w_ctl.illegal = (w_funct7 != 7'h00);
                end else if (w_funct3 == 3'd5) begin
                    if (w_funct7 == 7'h20) begin
                        w_ctl.alu_ctl = ALU_SRA;
                    end else if (w_funct7 != 7'h00) begin
                        w_ctl.illegal = 1'b1;
                    end
                end
            end
            OPC_OP: begin
                w_ctl.reg_wr   = 1'b1;
                w_uses_rs1     = 1'b1;
                w_uses_rs2     = 1'b1;
                case (w_funct7)
                    7'h00: w_ctl.alu_ctl = base_alu(w_funct3);
                    7'h20: begin
                        if (w_funct3 == 3'd0) begin
                            w_ctl.alu_ctl = ALU_SUB;
                        end else if (w_funct3 == 3'd5) begin
                            w_ctl.alu_ctl = ALU_SRA;
                        end else begin
                            w_ctl.illegal = 1'b1;
                        end
                    end
                    7'h01: begin
                        if (M_EXT != 0) begin
                            w_ctl.alu_ctl = ALU_MUL + {2'b00, w_funct3};
                        end else begin
                            w_ctl.illegal = 1'b1;
                        end
                    end
                    default: w_ctl.illegal = 1'b1;
                endcase
            end
            default: w_ctl.illegal = 1'b1;
        endcase
        if (w_ctl.illegal) begin
            w_ctl.reg_wr = 1'b0;
            w_ctl.mem_rd = 1'b0;
            w_ctl.mem_wr = 1'b0;
            w_ctl.branch = 1'b0;
            w_ctl.jump   = 1'b0;
        end
    end

    assign o_ctl      = w_ctl;
    assign o_imm      = XLEN'($signed(w_imm32));
    assign o_uses_rs1 = w_uses_rs1;
    assign o_uses_rs2 = w_uses_rs2;

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module : decode_stage
// Brief  : Registered decode stage with valid/ready handshake and load-use stall.
// Rev    : 1.0  initial release
// ============================================================================
module decode_stage
    import rv_decode_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int M_EXT    = 1,
    parameter int LOAD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_alu_ctl,
    output logic            out_alu_src1,
    output logic            out_alu_src2,
    output logic [1:0]      out_wb_sel,
    output logic            out_reg_wr,
    output logic            out_mem_rd,
    output logic            out_mem_wr,
    output logic [2:0]      out_rw_type,
    output logic            out_branch,
    output logic [2:0]      out_br_type,
    output logic            out_jump,
    output logic            out_illegal
);

    localparam logic [1:0] LAT_INIT = 2'(LOAD_LAT);

    dec_ctl_t        w_dec;
    logic [XLEN-1:0] w_imm;
    logic            w_uses_rs1;
    logic            w_uses_rs2;

    rv_inst_decode #(
        .XLEN  (XLEN),
        .M_EXT (M_EXT)
    ) u_dec (
        .i_inst     (in_inst),
        .o_ctl      (w_dec),
        .o_imm      (w_imm),
        .o_uses_rs1 (w_uses_rs1),
        .o_uses_rs2 (w_uses_rs2)
    );

    logic            r_valid;
    dec_ctl_t        r_ctl;
    logic [XLEN-1:0] r_imm;
    logic [XLEN-1:0] r_pc;
    logic [4:0]      r_load_rd;
    logic [1:0]      r_count;

    logic w_held_load;
    logic w_trk_live;
    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_hazard;
    logic w_accept;
    logic w_depart;
    logic w_load_dep;

    // A load still in the output register or inside its latency window blocks consumers.
    assign w_held_load = r_valid && r_ctl.mem_rd && (r_ctl.rd != 5'd0);
    assign w_trk_live  = (r_count != 2'd0) && (r_load_rd != 5'd0);
    assign w_rs1_hit   = w_uses_rs1 && (w_dec.rs1 != 5'd0) &&
                         ((w_held_load && (w_dec.rs1 == r_ctl.rd)) ||
                          (w_trk_live && (w_dec.rs1 == r_load_rd)));
    assign w_rs2_hit   = w_uses_rs2 && (w_dec.rs2 != 5'd0) &&
                         ((w_held_load && (w_dec.rs2 == r_ctl.rd)) ||
                          (w_trk_live && (w_dec.rs2 == r_load_rd)));
    assign w_hazard    = in_valid && (w_rs1_hit || w_rs2_hit);

    assign in_ready    = rst_n && (!r_valid || out_ready) && !w_hazard && !flush;
    assign w_accept    = in_valid && in_ready;
    assign w_depart    = r_valid && out_ready;
    assign w_load_dep  = w_depart && r_ctl.mem_rd && (r_ctl.rd != 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_ctl     <= '0;
            r_imm     <= '0;
            r_pc      <= '0;
            r_load_rd <= '0;
            r_count   <= '0;
        end else if (flush) begin
            r_valid   <= 1'b0;
            r_count   <= '0;
        end else begin
            if (w_accept) begin
                r_valid <= 1'b1;
                r_ctl   <= w_dec;
                r_imm   <= w_imm;
                r_pc    <= in_pc;
            end else if (w_depart) begin
                r_valid <= 1'b0;
            end
            if (w_load_dep) begin
                r_load_rd <= r_ctl.rd;
                r_count   <= LAT_INIT;
            end else if (r_count != 2'd0) begin
                r_count   <= r_count - 2'd1;
            end
        end
    end

    assign out_valid    = r_valid;
    assign out_pc       = r_pc;
    assign out_imm      = r_imm;
    assign out_rs1      = r_ctl.rs1;
    assign out_rs2      = r_ctl.rs2;
    assign out_rd       = r_ctl.rd;
    assign out_alu_ctl  = r_ctl.alu_ctl;
    assign out_alu_src1 = r_ctl.alu_src1;
    assign out_alu_src2 = r_ctl.alu_src2;
    assign out_wb_sel   = r_ctl.wb_sel;
    assign out_reg_wr   = r_ctl.reg_wr;
    assign out_mem_rd   = r_ctl.mem_rd;
    assign out_mem_wr   = r_ctl.mem_wr;
    assign out_rw_type  = r_ctl.rw_type;
    assign out_branch   = r_ctl.branch;
    assign out_br_type  = r_ctl.br_type;
    assign out_jump     = r_ctl.jump;
    assign out_illegal  = r_ctl.illegal;

endmodule
`default_nettype wire

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width of out_imm/in_pc/out_pc (legal 32 or 64).
REQ-002 SHALL have parameter M_EXT, default 1; 1 decodes RV32M, 0 flags M ops illegal.
REQ-003 SHALL have parameter LOAD_LAT, default 1, cycles a load result is unavailable after the load leaves this stage (legal 1..3).
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  clock, rising edge; rst_n  in  1  async active-low reset.
REQ-005 SHALL have: in_valid  in  1  instruction valid; in_ready  out  1  stage accepts; in_inst  in  32  instruction; in_pc  in  XLEN  its PC.
REQ-006 SHALL have: flush  in  1  discard held instruction and hazard state.
REQ-007 SHALL have: out_valid  out  1; out_ready  in  1; out_pc  out  XLEN; out_rs1/out_rs2/out_rd  out  5 each.
REQ-008 SHALL have: out_imm  out  XLEN  sign-extended immediate; out_alu_ctl  out  5; out_alu_src1  out  1  (1=PC); out_alu_src2  out  1  (1=imm).
REQ-009 SHALL have: out_wb_sel  out  2  (0=PC+4, 1=ALU, 2=imm, 3=mem); out_reg_wr, out_mem_rd, out_mem_wr  out  1 each; out_rw_type  out  3  (funct3).
REQ-010 SHALL have: out_branch  out  1; out_br_type  out  3  (branch funct3); out_jump  out  1  (jal/jalr); out_illegal  out  1.

Function
REQ-011 SHALL decode opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP into the registered out_* fields; latency 1 cycle from accept to out_valid.
REQ-012 SHALL form immediates per RV I/S/B/U/J formats, sign-extended from bit 31 to XLEN; U-type = {inst[31:12],12'b0} then sign-extended.
REQ-013 SHALL encode out_alu_ctl: ADD 0, SUB 1, MUL 2, MULH 3, MULHSU 4, MULHU 5, DIV 6, DIVU 7, REM 8, REMU 9, AND 10, OR 11, XOR 12, SLL 14, SRL 15, SRA 16, SLTU 17, SLT 18; non-ALU ops use ADD.
REQ-014 SHALL set out_illegal for unknown opcode, undefined funct3/funct7 combos (incl. slli/srli/srai with bad funct7, branch funct3 2/3, load funct3 3/6/7, store funct3 >2), or any funct7=0x01 OP when M_EXT=0.
REQ-015 Illegal instructions SHALL still pass through with out_reg_wr=out_mem_rd=out_mem_wr=out_branch=out_jump=0.
REQ-016 Handshake: accept when in_valid && in_ready; in_ready = (!out_valid || out_ready) && !hazard && !flush.
REQ-017 Output fields SHALL stay stable while out_valid && !out_ready; no instruction dropped or duplicated.
REQ-018 Hazard tracker: when a load with rd!=0 leaves (out_valid && out_ready && out_mem_rd), latch load_rd and set countdown to LOAD_LAT; countdown decrements by 1 per cycle to 0; a new departing load reloads it.
REQ-019 hazard SHALL be 1 when in_valid and the incoming instruction reads rs1 (or rs2, per format) equal to a nonzero rd of either a load held in the output register or load_rd with countdown!=0.
REQ-020 LUI/AUIPC/JAL SHALL not read rs; I-type/loads/JALR read rs1 only; R/S/B read both; reads of x0 never hazard.
REQ-021 flush SHALL, on the next edge, clear out_valid and countdown; flush has priority over accept and departure.
REQ-022 Simultaneous departure and accept SHALL load the new instruction in the same cycle (full throughput, one instruction/cycle).

Reset
REQ-023 On rst_n low, out_valid, countdown, load_rd and all out_* fields SHALL clear to 0 asynchronously; in_ready is 0 while rst_n is low.
REQ-024 First accept SHALL be possible the first rising edge after rst_n deasserts.

Structure
REQ-025 Opcode constants, alu_ctl codes, wb_sel codes and the decoded-control bundle type SHALL live in shared package rv_decode_pkg.
REQ-026 Combinational field/immediate/legality decode SHALL be a sub-module rv_inst_decode; decode_stage holds the pipeline register, handshake and hazard tracker.

Verification
REQ-027 addi x1,x0,5 (0x00500093), out_ready=1 -> next cycle out_valid=1, rd=1, imm=5, alu_ctl=0, alu_src2=1, wb_sel=1, reg_wr=1.
REQ-028 lw x2,0(x1) (0x0000A103) then add x3,x2,x1 (0x001101B3), LOAD_LAT=1 -> in_ready=0 while load is held plus 1 cycle; add then issues with rs1=2, rs2=1.
REQ-029 out_ready=0 for 3 cycles with in_valid=1 -> out fields unchanged, in_ready=0; after release each instruction appears exactly once in order.
REQ-030 mul x5,x6,x7 (0x027302B3): M_EXT=0 -> out_illegal=1, reg_wr=0; M_EXT=1 -> alu_ctl=2, reg_wr=1.
REQ-031 flush with out_valid=1 and countdown=1 -> next cycle out_valid=0; dependent add accepted the same cycle flush drops.
REQ-032 rst_n pulsed low mid-stream -> out_valid=0 immediately without a clock edge; jal x1,-4 (0xFFDFF0EF) after release -> imm=0xFFFFFFFC, jump=1, wb_sel=0.
